// File: rtl/mv_pkg.sv
// Shared types and helpers for the mv streaming engine.
// The state enum, default geometry and the result-width rule live here so
// the engine, its FIFO and the bench all derive sizes the same way.
package mv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MV_N  = 4;
  localparam int MV_DW = 8;

  // One matrix lane and one matrix row at the default geometry.
  typedef logic [MV_DW-1:0]  lane_t;
  typedef lane_t [0:MV_N-1]  row_t;

  // Exact width of an N-term sum of DW x DW products.
  function automatic int res_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mv_out_fifo.sv
// Synchronous result FIFO for the mv engine.
// Head entry is visible on pop_data while not empty; count reports occupancy.
// Pushing into a full FIFO is dropped here; the engine's credit check keeps
// that from happening.
module mv_out_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    pop_data,
  output logic            empty,
  output logic            full,
  output logic [CNTW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mv_stream_engine.sv
// Streaming matrix-vector engine: y[r] = sum_j A[r][j] * x[j].
// x is loaded into a register bank while idle; A rows stream in over
// row_valid/row_ready, y elements stream out over res_valid/res_ready.
// Stage 1 registers the N lane products; the adder tree feeds the FIFO
// directly, so the FIFO entry is the second pipeline register.
// Build option: MV_STREAM_ENGINE_SIGNED_EN selects two's complement operands
// (products and sum signed, result sign-extended); otherwise all unsigned.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; x bank writable
// ST_RUN   | accepting A rows until cfg_rows have been taken
// ST_DRAIN | all rows taken; waiting for the last result handshake
// ST_DONE  | one cycle, done pulse, back to idle
module mv_stream_engine
  import mv_pkg::*;
#(
  parameter  int N         = MV_N,
  parameter  int DW        = MV_DW,
  parameter  int MAX_ROWS  = 16,
  parameter  int OUT_DEPTH = 4,
  localparam int RW        = res_width(N, DW),
  localparam int CW        = $clog2(MAX_ROWS + 1),
  localparam int IW        = $clog2(MAX_ROWS),
  localparam int AW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        cfg_rows,
  output logic                 busy,
  output logic                 done,
  input  logic                 vec_we,
  input  logic [AW-1:0]        vec_addr,
  input  logic [DW-1:0]        vec_data,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [0:N-1][DW-1:0] row_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RW-1:0]        res_data,
  output logic [IW-1:0]        res_idx,
  output logic                 res_last
);

  localparam int FW   = RW + IW + 1;
  localparam int CNTW = $clog2(OUT_DEPTH) + 1;
  localparam int EXT  = RW - 2 * DW;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       rows_cfg;
  logic [CW-1:0]       rows_acc;
  logic [CW-1:0]       cfg_clamped;
  logic [DW-1:0]       x_bank [N];
  logic [2*DW-1:0]     prod_c [N];
  logic [2*DW-1:0]     s1_prod [N];
  logic                s1_valid;
  logic                s1_last;
  logic [IW-1:0]       s1_idx;
  logic [RW-1:0]       sum_c;
  logic                row_fire;
  logic                row_last;
  logic                credit_ok;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNTW-1:0]     fifo_count;
  logic [FW-1:0]       fifo_head;

  assign cfg_clamped = (cfg_rows > CW'(MAX_ROWS)) ? CW'(MAX_ROWS) : cfg_rows;
  assign row_fire    = row_valid && row_ready;
  assign row_last    = (rows_acc == rows_cfg - CW'(1));
  // A row is only taken if a FIFO slot is guaranteed for it and for the
  // product already sitting in stage 1.
  assign credit_ok   = (CNTW'(s1_valid) + fifo_count) < CNTW'(OUT_DEPTH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = (cfg_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (row_fire && row_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (res_valid && res_ready && res_last) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    row_ready = (state == ST_RUN) && credit_ok;
  end

  // Job length capture and accepted-row counter (also the result index).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_cfg <= '0;
      rows_acc <= '0;
    end else if (state == ST_IDLE && start) begin
      rows_cfg <= cfg_clamped;
      rows_acc <= '0;
    end else if (row_fire) begin
      rows_acc <= rows_acc + CW'(1);
    end
  end

  // x bank: writable only while idle, persists across jobs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) x_bank[j] <= '0;
    end else if (state == ST_IDLE && vec_we) begin
      x_bank[vec_addr] <= vec_data;
    end
  end

  // Lane products, operands extended to full product width first.
  always_comb begin
    for (int j = 0; j < N; j++) begin
`ifdef MV_STREAM_ENGINE_SIGNED_EN
      prod_c[j] = $signed({{DW{x_bank[j][DW-1]}}, x_bank[j]}) *
                  $signed({{DW{row_data[j][DW-1]}}, row_data[j]});
`else
      prod_c[j] = {{DW{1'b0}}, x_bank[j]} * {{DW{1'b0}}, row_data[j]};
`endif
    end
  end

  // Stage 1: register products with the row's index and last flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      for (int j = 0; j < N; j++) s1_prod[j] <= '0;
    end else begin
      s1_valid <= row_fire;
      if (row_fire) begin
        s1_last <= row_last;
        s1_idx  <= rows_acc[IW-1:0];
        for (int j = 0; j < N; j++) s1_prod[j] <= prod_c[j];
      end
    end
  end

  // Adder tree over the stage-1 products at full result width.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < N; j++) begin
`ifdef MV_STREAM_ENGINE_SIGNED_EN
      sum_c = sum_c + {{EXT{s1_prod[j][2*DW-1]}}, s1_prod[j]};
`else
      sum_c = sum_c + {{EXT{1'b0}}, s1_prod[j]};
`endif
    end
  end

  mv_out_fifo #(
    .W     (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid),
    .push_data ({s1_last, s1_idx, sum_c}),
    .pop       (res_valid && res_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Result port shows the FIFO head, forced to zero when nothing is queued.
  assign res_valid = !fifo_empty;
  assign {res_last, res_idx, res_data} = res_valid ? fifo_head : '0;

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(s1_valid && fifo_full));

endmodule

// File: tb/tb_mv_stream_engine.sv
// Self-checking bench for mv_stream_engine: stimulus pushes expected results
// into a scoreboard queue, an independent monitor pops and compares on every
// result handshake.
module tb_mv_stream_engine;
  import mv_pkg::*;

  localparam int N = 4, DW = 8, MAX_ROWS = 16, OUT_DEPTH = 4;
  localparam int RW = 18, CW = 5, IW = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
    logic [RW-1:0] data;
  } exp_t;

  logic clk = 0;
  logic rst, start, busy, done, vec_we, row_valid, row_ready;
  logic res_valid, res_ready, res_last;
  logic [CW-1:0] cfg_rows;
  logic [1:0]    vec_addr;
  logic [DW-1:0] vec_data;
  row_t          row_data;
  logic [RW-1:0] res_data;
  logic [IW-1:0] res_idx;

  mv_stream_engine #(.N(N), .DW(DW), .MAX_ROWS(MAX_ROWS), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .busy(busy), .done(done),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_data(vec_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   rr_mode = 0;
  int   job_rows = 0, job_idx = 0;
  int   job_start_cyc = 0, first_acc_cyc = 0, first_res_cyc = -1;
  int   last_hs_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [DW-1:0] mx [N];
  exp_t exp_q[$];
  row_t row_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer dot product, truncated to the result width.
  function automatic logic [RW-1:0] model_y(input row_t a);
    longint acc = 0;
    for (int j = 0; j < N; j++) begin
`ifdef MV_STREAM_ENGINE_SIGNED_EN
      acc += longint'($signed(mx[j])) * longint'($signed(a[j]));
`else
      acc += longint'(mx[j]) * longint'(a[j]);
`endif
    end
    return RW'(acc);
  endfunction

  function automatic int clamp_rows(input int c);
    return (c > MAX_ROWS) ? MAX_ROWS : c;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < N; j++) r[j] = DW'($urandom);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    res_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Monitor: compares every handshaken result and checks hold-under-backpressure.
  initial begin
    automatic bit hold = 0;
    automatic logic [63:0] hold_val = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_payload", {res_last, res_idx, res_data}, hold_val);
      end
      if (res_valid && first_res_cyc < job_start_cyc) first_res_cyc = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got idx %0d data %0d, expected no result", res_idx, res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_idx", res_idx, e.idx);
          check("res_data", res_data, e.data);
          check("res_last", res_last, e.last);
          if (res_last) last_hs_cyc = cyc;
        end
      end
      hold = res_valid && !res_ready;
      hold_val = {res_last, res_idx, res_data};
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic load_x(input row_t v);
    for (int j = 0; j < N; j++) begin
      vec_we = 1; vec_addr = 2'(j); vec_data = v[j];
      @(posedge clk); #1;
      mx[j] = v[j];
    end
    vec_we = 0;
  endtask

  task automatic begin_job(input int cfg);
    job_start_cyc = cyc;
    start = 1; cfg_rows = CW'(cfg);
    job_rows = clamp_rows(cfg); job_idx = 0;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_row(input row_t r);
    bit   acc = 0;
    exp_t e;
    row_valid = 1; row_data = r;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = row_ready;
      if (acc && job_idx == 0) first_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    if (acc) begin
      e.idx = IW'(job_idx); e.last = (job_idx == job_rows - 1); e.data = model_y(r);
      exp_q.push_back(e);
      job_idx++;
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL row_accept_timeout: row %0d not accepted, expected acceptance", job_idx);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 400 && done_cnt == d0; k++) @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt, d0 + 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_row_ready", row_ready, 0);
  endtask

  task automatic run_job(input int cfg, input bit poke_start, input bit poke_vec);
    int d0 = done_cnt;
    int n  = clamp_rows(cfg);
    row_t r;
    begin_job(cfg);
    if (poke_vec) begin
      vec_we = 1; vec_addr = 2'($urandom_range(0, 3)); vec_data = ~mx[vec_addr];
      @(posedge clk); #1;
      vec_we = 0;
    end
    for (int i = 0; i < n; i++) begin
      r = (row_q.size() != 0) ? row_q.pop_front() : rand_row();
      if (poke_start && i == 1) begin start = 1; cfg_rows = 5'd5; end
      send_row(r);
      start = 0;
    end
    row_valid = 0;
    wait_done(d0);
  endtask

  initial begin
    row_t v;
    int   d0;
    rst = 1; start = 0; cfg_rows = '0; vec_we = 0; vec_addr = '0; vec_data = '0;
    row_valid = 0; row_data = '0;
    for (int j = 0; j < N; j++) mx[j] = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row_ready", row_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_last", res_last, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_idx", res_idx, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Basic two-row job with latency and done timing.
    v = {8'd1, 8'd2, 8'd3, 8'd4};
    load_x(v);
    row_q.push_back({8'd1, 8'd1, 8'd1, 8'd1});
    row_q.push_back({8'd2, 8'd0, 8'd0, 8'd1});
    rr_mode = 0;
    run_job(2, 0, 0);
    check("first_result_latency", first_res_cyc - first_acc_cyc, 2);
    check("done_after_last_hs", done_cyc - last_hs_cyc, 1);

    // Backpressure: credit limits acceptance to the FIFO depth.
    rr_mode = 2;
    d0 = done_cnt;
    begin_job(8);
    fork
      for (int i = 0; i < 8; i++) send_row(rand_row());
      begin
        repeat (12) @(posedge clk);
        #2;
        check("accepted_under_bp", job_idx, OUT_DEPTH);
        check("row_ready_under_bp", row_ready, 0);
        rr_mode = 0;
      end
    join
    row_valid = 0;
    wait_done(d0);

    // Extremes.
    v = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_x(v);
    for (int i = 0; i < 3; i++) row_q.push_back(v);
    run_job(3, 0, 0);
`ifdef MV_STREAM_ENGINE_SIGNED_EN
    v = {8'h80, 8'h80, 8'h80, 8'h80};
    load_x(v);
    for (int i = 0; i < 2; i++) row_q.push_back(v);
    run_job(2, 0, 0);
`endif

    // Zero-row job, then start ignored while busy.
    run_job(0, 0, 0);
    check("zero_rows_done_delay", done_cyc - job_start_cyc, 1);
    run_job(3, 1, 0);

    // x writes while busy are ignored; the following jobs keep the old x.
    v = rand_row();
    load_x(v);
    run_job(4, 0, 1);
    rr_mode = 1;
    for (int t = 0; t < 6; t++) begin
      if (t == 3) load_x(rand_row());
      run_job(int'($urandom_range(1, 31)), 0, (t % 2) == 1);
    end

    // Reset in the middle of a job with results pending.
    rr_mode = 2;
    begin_job(5);
    for (int i = 0; i < 3; i++) send_row(rand_row());
    row_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("pending_before_rst", res_valid, 1);
    d0 = done_cnt;
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_row_ready", row_ready, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_data", res_data, 0);
    check("abort_res_idx", res_idx, 0);
    check("abort_res_last", res_last, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    for (int j = 0; j < N; j++) mx[j] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    rr_mode = 0;
    @(posedge clk); #1;
    check("no_done_after_abort", done_cnt, d0);
    run_job(2, 0, 0);
    load_x(rand_row());
    rr_mode = 1;
    run_job(6, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
